// File: rtl/distance_zone_if.sv
// distance_zone_if: echo-measurement input and alert-output bundle for distance_zone_ctrl
//   master: drives width_i/valid_i/mode_i, observes zone/tone/led outputs
//   slave : the controller side
interface distance_zone_if #(
    parameter int W = 16,
    parameter int LIMIT_W = 20
);
    logic [W-1:0] width_i;
    logic valid_i;
    logic mode_i;
    logic [3:0] zone_o;
    logic [LIMIT_W-1:0] count_limit_o;
    logic tone_en_o;
    logic led_o;
    logic zone_change_o;
    modport master (
        output width_i, valid_i, mode_i,
        input zone_o, count_limit_o, tone_en_o, led_o, zone_change_o
    );
    modport slave (
        input width_i, valid_i, mode_i,
        output zone_o, count_limit_o, tone_en_o, led_o, zone_change_o
    );
endinterface

// File: rtl/distance_zone_ctrl.sv
// distance_zone_ctrl: averages echo widths, commits a hysteretic distance zone and drives tone/LED
//   clk_i    : single clock
//   reset_ni : asynchronous active-low reset
//   bus      : width_i/valid_i/mode_i in; zone_o, count_limit_o, tone_en_o, led_o, zone_change_o out
module distance_zone_ctrl #(
    parameter int W = 16,
    parameter int ZONES = 3,
    parameter int CYC_PER_CM = 350,
    parameter int MIN_CM = 15,
    parameter logic [ZONES*8-1:0] EDGE_CM = {8'd100, 8'd50, 8'd30},
    parameter int HYST_CM = 2,
    parameter int AVG_LOG2 = 1,
    parameter int CONFIRM = 3,
    parameter int BASE_LIMIT = 18375,
    parameter int LIMIT_W = 20,
    parameter int TIMEOUT_CYC = 1200000,
    parameter int BEEP_ON = 1200000
) (
    input logic clk_i,
    input logic reset_ni,
    distance_zone_if.slave bus
);
    localparam int N = 1 << AVG_LOG2;
    localparam int SW = W + AVG_LOG2;
    localparam int PW = AVG_LOG2 > 0 ? AVG_LOG2 : 1;
    localparam int FW = $clog2(N + 1);
    localparam int KW = $clog2(CONFIRM + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int CW = $clog2(ZONES * BEEP_ON + 1);
    localparam int H = HYST_CM * CYC_PER_CM;
    if (ZONES < 1 || ZONES > 8) begin : g_zones_chk
        $error("ZONES must be in 1..8");
    end
    if ((64'(BASE_LIMIT) << (ZONES - 1)) >= (64'd1 << LIMIT_W)) begin : g_limit_chk
        $error("BASE_LIMIT << (ZONES-1) does not fit in LIMIT_W bits");
    end
    // Boundary j in cycles, shifted away from the committed zone z (encoded 1..ZONES, 0 = silent).
    function automatic int thr(input int j, input logic [3:0] z);
        int b;
        b = MIN_CM * CYC_PER_CM;
        if (j > 0) b = int'(8'(EDGE_CM >> (8 * (j - 1)))) * CYC_PER_CM;
        return z == 4'd0 ? b : (j >= int'(z) ? b + H : b - H);
    endfunction
    logic [W-1:0] ring_q [N];
    logic [PW-1:0] ptr_q;
    logic [FW-1:0] fill_q;
    logic [SW-1:0] sum_q;
    logic [W-1:0] avg_q;
    logic s1_q, avg_v_q, mode_q, beep_on_q, beep_on_n, led_q, tone_q, chg_q, full, expire, restart, tone_n;
    logic [3:0] zone_q, cand_q, raw, zone_n, cand_n;
    logic [KW-1:0] cnt_q, cnt_n;
    logic [TW-1:0] idle_q;
    logic [CW-1:0] beep_cnt_q, beep_cnt_n;
    logic [LIMIT_W-1:0] limit_q;
    assign full = fill_q == FW'(N);
    // valid_i in the expiry cycle keeps the sensor alive
    assign expire = !bus.valid_i && idle_q == TW'(TIMEOUT_CYC - 1);
    always_comb begin
        raw = 4'd0;
        if (int'(avg_q) >= thr(0, zone_q) && int'(avg_q) < thr(ZONES, zone_q)) begin
            raw = 4'd1;
            for (int j = 1; j < ZONES; j++) if (int'(avg_q) >= thr(j, zone_q)) raw = 4'(j + 1);
        end
    end
    always_comb begin
        zone_n = zone_q;
        cand_n = cand_q;
        cnt_n = cnt_q;
        if (expire) begin
            zone_n = 4'd0;
            cand_n = 4'd0;
            cnt_n = '0;
        end else if (avg_v_q) begin
            if (raw == zone_q) cnt_n = '0;
            else begin
                cand_n = raw;
                cnt_n = raw == cand_q ? cnt_q + 1'b1 : KW'(1);
                if (cnt_n >= KW'(CONFIRM)) begin
                    zone_n = raw;
                    cnt_n = '0;
                end
            end
        end
        restart = zone_n != zone_q || bus.mode_i != mode_q;
        beep_on_n = beep_on_q;
        beep_cnt_n = beep_cnt_q + 1'b1;
        if (restart) begin
            beep_on_n = 1'b1;
            beep_cnt_n = '0;
        end else if (beep_on_q && beep_cnt_q == CW'(BEEP_ON - 1)) begin
            beep_on_n = 1'b0;
            beep_cnt_n = '0;
        end else if (!beep_on_q && beep_cnt_q == CW'((int'(zone_q) - 1) * BEEP_ON - 1)) begin
            beep_on_n = 1'b1;
            beep_cnt_n = '0;
        end
        // zone 0 and continuous mode bypass the cadence
        tone_n = zone_n != 4'd0 && (!bus.mode_i || zone_n == 4'd1 || beep_on_n);
    end
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int i = 0; i < N; i++) ring_q[i] <= '0;
            ptr_q <= '0;
            fill_q <= '0;
            sum_q <= '0;
            avg_q <= '0;
            s1_q <= 1'b0;
            avg_v_q <= 1'b0;
            idle_q <= '0;
            zone_q <= 4'd0;
            cand_q <= 4'd0;
            cnt_q <= '0;
            mode_q <= 1'b0;
            beep_on_q <= 1'b0;
            beep_cnt_q <= '0;
            limit_q <= '0;
            led_q <= 1'b0;
            tone_q <= 1'b0;
            chg_q <= 1'b0;
        end else begin
            if (bus.valid_i) begin
                ring_q[ptr_q] <= bus.width_i;
                ptr_q <= N == 1 ? '0 : ptr_q + 1'b1;
                // while filling the old slots hold stale data, so nothing is subtracted
                sum_q <= sum_q + SW'(bus.width_i) - (full ? SW'(ring_q[ptr_q]) : '0);
                fill_q <= full ? fill_q : fill_q + 1'b1;
            end else if (expire) begin
                sum_q <= '0;
                fill_q <= '0;
            end
            s1_q <= bus.valid_i && fill_q >= FW'(N - 1);
            avg_q <= W'(sum_q >> AVG_LOG2);
            avg_v_q <= s1_q;
            idle_q <= bus.valid_i ? '0 : (idle_q == TW'(TIMEOUT_CYC) ? idle_q : idle_q + 1'b1);
            zone_q <= zone_n;
            cand_q <= cand_n;
            cnt_q <= cnt_n;
            mode_q <= bus.mode_i;
            beep_on_q <= beep_on_n;
            beep_cnt_q <= beep_cnt_n;
            limit_q <= zone_n == 4'd0 ? '0 : LIMIT_W'(BASE_LIMIT) << (zone_n - 4'd1);
            led_q <= zone_n != 4'd0;
            tone_q <= tone_n;
            chg_q <= zone_n != zone_q;
        end
    end
    assign bus.zone_o = zone_q;
    assign bus.count_limit_o = limit_q;
    assign bus.led_o = led_q;
    assign bus.tone_en_o = tone_q;
    assign bus.zone_change_o = chg_q;
endmodule

// File: tb/tb_distance_zone_ctrl.sv
// tb_distance_zone_ctrl: scoreboard bench for distance_zone_ctrl with directed echo-width vectors
module tb_distance_zone_ctrl;
    localparam int W = 16;
    localparam int LIMIT_W = 20;
    localparam int TO = 200;
    localparam int BEEP = 10;
    typedef struct packed {
        logic [3:0] zone;
        logic [LIMIT_W-1:0] limit;
        logic led;
    } exp_t;
    logic clk_i = 1'b0;
    logic reset_ni = 1'b0;
    int total = 0;
    int bad = 0;
    exp_t exp_q[$];
    distance_zone_if #(.W(W), .LIMIT_W(LIMIT_W)) bus ();
    distance_zone_ctrl #(.TIMEOUT_CYC(TO), .BEEP_ON(BEEP)) dut (
        .clk_i(clk_i),
        .reset_ni(reset_ni),
        .bus(bus)
    );
    always #5 clk_i = ~clk_i;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", nm, act, exp);
        end
    endtask
    task automatic push(input logic [3:0] z, input int l, input logic led);
        exp_q.push_back({z, LIMIT_W'(l), led});
    endtask
    task automatic send(input logic [W-1:0] w, input int gap);
        bus.width_i = w;
        bus.valid_i = 1'b1;
        @(negedge clk_i);
        bus.valid_i = 1'b0;
        repeat (gap) @(negedge clk_i);
    endtask
    task automatic chk_out(input string nm, input logic [3:0] z, input int l, input logic led, input logic tone);
        chk({nm, "_zone"}, 32'(bus.zone_o), 32'(z));
        chk({nm, "_limit"}, 32'(bus.count_limit_o), 32'(l));
        chk({nm, "_led"}, 32'(bus.led_o), 32'(led));
        chk({nm, "_tone"}, 32'(bus.tone_en_o), 32'(tone));
    endtask
    always @(negedge clk_i) begin : monitor
        exp_t e;
        if (reset_ni && bus.zone_change_o) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_change: zone_o=%0d with no commit expected", bus.zone_o);
            end else begin
                e = exp_q.pop_front();
                chk("sb_zone", 32'(bus.zone_o), 32'(e.zone));
                chk("sb_limit", 32'(bus.count_limit_o), 32'(e.limit));
                chk("sb_led", 32'(bus.led_o), 32'(e.led));
            end
        end
    end
    initial begin
        bus.width_i = '0;
        bus.valid_i = 1'b0;
        bus.mode_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk_out("reset", 4'd0, 0, 1'b0, 1'b0);
        chk("reset_change", 32'(bus.zone_change_o), 32'd0);
        reset_ni = 1'b1;
        @(negedge clk_i);
        push(4'd1, 18375, 1'b1);
        for (int i = 0; i < 3; i++) send(16'd7000, 9);
        chk("pre4_zone", 32'(bus.zone_o), 32'd0);
        send(16'd7000, 0);
        chk("t0_zone", 32'(bus.zone_o), 32'd0);
        @(negedge clk_i);
        chk("t1_zone", 32'(bus.zone_o), 32'd0);
        @(negedge clk_i);
        chk_out("commit", 4'd1, 18375, 1'b1, 1'b1);
        repeat (5) send(16'd10800, 2);
        chk("hyst_hold0", 32'(bus.zone_o), 32'd1);
        push(4'd2, 36750, 1'b1);
        repeat (5) send(16'd11300, 2);
        chk_out("hyst_up", 4'd2, 36750, 1'b1, 1'b1);
        repeat (5) send(16'd10000, 2);
        chk("hyst_hold1", 32'(bus.zone_o), 32'd2);
        push(4'd1, 18375, 1'b1);
        repeat (5) send(16'd9700, 2);
        chk_out("hyst_down", 4'd1, 18375, 1'b1, 1'b1);
        repeat (4) send(16'd7000, 0);
        send(16'd40000, 0);
        repeat (3) send(16'd7000, 2);
        chk("outlier_zone", 32'(bus.zone_o), 32'd1);
        push(4'd0, 0, 1'b0);
        repeat (5) send(16'd4000, 2);
        chk_out("near", 4'd0, 0, 1'b0, 1'b0);
        repeat (5) send(16'd36000, 2);
        chk_out("far", 4'd0, 0, 1'b0, 1'b0);
        repeat (3) send(16'd0, 2);
        repeat (3) send(16'hFFFF, 2);
        chk("extreme_zone", 32'(bus.zone_o), 32'd0);
        push(4'd1, 18375, 1'b1);
        repeat (4) send(16'd7000, 2);
        send(16'd7000, 0);
        push(4'd0, 0, 1'b0);
        repeat (TO - 1) @(negedge clk_i);
        chk("pre_timeout_zone", 32'(bus.zone_o), 32'd1);
        @(negedge clk_i);
        chk_out("timeout", 4'd0, 0, 1'b0, 1'b0);
        push(4'd1, 18375, 1'b1);
        send(16'd7000, 2);
        send(16'd7000, 2);
        send(16'd7000, 0);
        @(negedge clk_i);
        @(negedge clk_i);
        chk("refill3_zone", 32'(bus.zone_o), 32'd0);
        send(16'd7000, 0);
        @(negedge clk_i);
        @(negedge clk_i);
        chk("refill4_zone", 32'(bus.zone_o), 32'd1);
        bus.mode_i = 1'b1;
        @(negedge clk_i);
        push(4'd3, 73500, 1'b1);
        repeat (3) send(16'd20000, 2);
        send(16'd20000, 0);
        @(negedge clk_i);
        @(negedge clk_i);
        chk_out("beep_commit", 4'd3, 73500, 1'b1, 1'b1);
        for (int i = 1; i < 35; i++) begin
            @(negedge clk_i);
            chk($sformatf("beep_tone_%0d", i), 32'(bus.tone_en_o), 32'(i < 10 || i >= 30));
        end
        chk("beep_led", 32'(bus.led_o), 32'd1);
        #2 reset_ni = 1'b0;
        #1 chk_out("async_reset", 4'd0, 0, 1'b0, 1'b0);
        chk("async_reset_change", 32'(bus.zone_change_o), 32'd0);
        @(negedge clk_i);
        reset_ni = 1'b1;
        @(negedge clk_i);
        chk_out("post_reset", 4'd0, 0, 1'b0, 1'b0);
        chk("pending_commits", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
